// File: rtl/rv_boot_ctrl.sv
// Run-control sequencer for the rvMagic core: streams an image into I-mem, releases the
// core, then ends the run on a tohost store or a cycle-count timeout.
module rv_boot_ctrl #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           WORD_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int unsigned           MAX_WORDS   = 1024,
   parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 'h1000,
   parameter int unsigned           RST_HOLD    = 4,
   parameter int unsigned           TIMEOUT     = 1_000_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic                  ld_valid_i,
   output logic                  ld_ready_o,
   input  logic [WORD_WIDTH-1:0] ld_data_i,
   input  logic                  ld_last_i,
   output logic                  imem_we_o,
   output logic [ADDR_WIDTH-1:0] imem_waddr_o,
   output logic [WORD_WIDTH-1:0] imem_wdata_o,
   output logic                  core_rst_n_o,
   input  logic [ADDR_WIDTH-1:0] mon_addr_i,
   input  logic                  mon_write_i,
   input  logic [WORD_WIDTH-1:0] mon_data_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic                  timeout_o,
   output logic                  overflow_o,
   output logic [WORD_WIDTH-1:0] exit_code_o,
   output logic [31:0]           cycle_count_o
);

   localparam int unsigned WcntW = $clog2(MAX_WORDS) + 1;

   typedef enum logic [2:0] {StIdle, StLoad, StHold, StRun, StDone} state_e;

   state_e                state_q, state_d;
   logic [WcntW-1:0]      wcnt_q;
   logic [31:0]           hcnt_q;
   logic [31:0]           cycle_count_q;
   logic                  core_rst_n_q, pass_q, timeout_q, overflow_q;
   logic [WORD_WIDTH-1:0] exit_code_q;

   logic                  ld_hs, wcnt_full, tohost_hit, timeout_hit, hold_end;
   logic [ADDR_WIDTH-1:0] woff;

   assign ld_hs       = (state_q == StLoad) && ld_valid_i;
   assign wcnt_full   = (wcnt_q == WcntW'(MAX_WORDS - 1));
   assign tohost_hit  = (state_q == StRun) && mon_write_i && (mon_addr_i == TOHOST_ADDR);
   assign timeout_hit = (state_q == StRun) && (cycle_count_q == 32'(TIMEOUT - 1));
   assign hold_end    = (hcnt_q == 32'(RST_HOLD - 1));
   assign woff        = ADDR_WIDTH'(wcnt_q) << 2;

   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle, StDone: if (start_i) state_d = StLoad;
            StLoad: begin
               if (ld_hs) begin
                  if (ld_last_i)      state_d = StHold;
                  else if (wcnt_full) state_d = StDone;
               end
            end
            StHold:  if (hold_end) state_d = StRun;
            StRun:   if (tohost_hit || timeout_hit) state_d = StDone;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         wcnt_q        <= '0;
         hcnt_q        <= '0;
         cycle_count_q <= '0;
         core_rst_n_q  <= 1'b0;
         pass_q        <= 1'b0;
         timeout_q     <= 1'b0;
         overflow_q    <= 1'b0;
         exit_code_q   <= '0;
      end else begin
         state_q      <= state_d;
         core_rst_n_q <= (state_d == StRun);
         // Abort clears the flags but keeps cycle_count and exit_code for post-mortem.
         if (abort_i) begin
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
         end else begin
            case (state_q)
               StIdle, StDone: begin
                  if (start_i) begin
                     wcnt_q      <= '0;
                     pass_q      <= 1'b0;
                     timeout_q   <= 1'b0;
                     overflow_q  <= 1'b0;
                     exit_code_q <= '0;
                  end
               end
               StLoad: begin
                  if (ld_hs) begin
                     wcnt_q <= wcnt_q + WcntW'(1);
                     if (ld_last_i) begin
                        hcnt_q        <= '0;
                        cycle_count_q <= '0;
                     end else if (wcnt_full) begin
                        overflow_q <= 1'b1;
                     end
                  end
               end
               StHold: hcnt_q <= hcnt_q + 32'd1;
               StRun: begin
                  if (cycle_count_q != '1) cycle_count_q <= cycle_count_q + 32'd1;
                  // A tohost store in the timeout cycle takes precedence.
                  if (tohost_hit) begin
                     exit_code_q <= mon_data_i;
                     pass_q      <= (mon_data_i == WORD_WIDTH'(1));
                  end else if (timeout_hit) begin
                     timeout_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign ld_ready_o    = (state_q == StLoad);
   assign imem_we_o     = ld_hs;
   assign imem_waddr_o  = BASE_ADDR + woff;
   assign imem_wdata_o  = ld_data_i;
   assign core_rst_n_o  = core_rst_n_q;
   assign busy_o        = (state_q == StLoad) || (state_q == StHold) || (state_q == StRun);
   assign done_o        = (state_q == StDone);
   assign pass_o        = pass_q;
   assign timeout_o     = timeout_q;
   assign overflow_o    = overflow_q;
   assign exit_code_o   = exit_code_q;
   assign cycle_count_o = cycle_count_q;

endmodule

// File: tb/tb_rv_boot_ctrl.sv
// Directed bench for rv_boot_ctrl: a per-cycle vector table for load/run/pass, then
// hand-written sequences for fail code, timeout, overflow, abort and reset.
module tb_rv_boot_ctrl;

   logic        clk, rst_n;
   logic        start, abort, ld_valid, ld_ready, ld_last;
   logic [31:0] ld_data;
   logic        imem_we;
   logic [31:0] imem_waddr, imem_wdata;
   logic        core_rst_n;
   logic [31:0] mon_addr, mon_data;
   logic        mon_write;
   logic        busy, done, pass, timeout, overflow;
   logic [31:0] exit_code, cycle_count;

   int checks = 0;
   int errors = 0;

   rv_boot_ctrl #(
      .MAX_WORDS (4),
      .RST_HOLD  (4),
      .TIMEOUT   (50)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start),
      .abort_i       (abort),
      .ld_valid_i    (ld_valid),
      .ld_ready_o    (ld_ready),
      .ld_data_i     (ld_data),
      .ld_last_i     (ld_last),
      .imem_we_o     (imem_we),
      .imem_waddr_o  (imem_waddr),
      .imem_wdata_o  (imem_wdata),
      .core_rst_n_o  (core_rst_n),
      .mon_addr_i    (mon_addr),
      .mon_write_i   (mon_write),
      .mon_data_i    (mon_data),
      .busy_o        (busy),
      .done_o        (done),
      .pass_o        (pass),
      .timeout_o     (timeout),
      .overflow_o    (overflow),
      .exit_code_o   (exit_code),
      .cycle_count_o (cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        start, ld_valid, ld_last, mon_write;
      logic [31:0] ld_data, mon_addr, mon_data;
      logic        we;
      logic [31:0] waddr;
      logic        ld_ready, crst, busy, done, pass;
      logic [31:0] exit_code, cycle_count;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      start = 0; abort = 0; ld_valid = 0; ld_last = 0; ld_data = 0;
      mon_write = 0; mon_addr = 0; mon_data = 0;
   endtask

   // Start from IDLE/DONE, stream n words (ld_last on the final one) and step to the
   // first RUN cycle.
   task automatic go_run(input int n);
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      for (int i = 0; i < n; i++) begin
         ld_valid = 1; ld_data = 32'h500 + i; ld_last = (i == n - 1);
         @(negedge clk);
      end
      ld_valid = 0; ld_last = 0;
      repeat (4) @(negedge clk);
      #1;
      chk("run entered core_rst_n", core_rst_n, 1);
      chk("run entered cycle_count", cycle_count, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int we_cnt;
      // start ld_v last mon_w ld_data mon_addr mon_data | we waddr rdy crst busy done pass exit cc
      tbl[0]  = '{1, 0, 0, 0, 32'h0,  32'h0,    32'h0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'd0};
      tbl[1]  = '{0, 1, 0, 0, 32'h11, 32'h0,    32'h0, 1, 32'h0, 1, 0, 1, 0, 0, 32'h0, 32'd0};
      tbl[2]  = '{0, 0, 0, 0, 32'h0,  32'h0,    32'h0, 0, 32'h0, 1, 0, 1, 0, 0, 32'h0, 32'd0};
      tbl[3]  = '{0, 1, 0, 0, 32'h22, 32'h0,    32'h0, 1, 32'h4, 1, 0, 1, 0, 0, 32'h0, 32'd0};
      tbl[4]  = '{0, 1, 1, 0, 32'h33, 32'h0,    32'h0, 1, 32'h8, 1, 0, 1, 0, 0, 32'h0, 32'd0};
      tbl[5]  = '{0, 1, 0, 0, 32'h44, 32'h0,    32'h0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 32'd0};
      tbl[6]  = '{0, 0, 0, 1, 32'h0,  32'h1000, 32'h1, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 32'd0};
      tbl[7]  = '{0, 0, 0, 0, 32'h0,  32'h0,    32'h0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 32'd0};
      tbl[8]  = '{0, 0, 0, 0, 32'h0,  32'h0,    32'h0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 32'd0};
      tbl[9]  = '{0, 0, 0, 0, 32'h0,  32'h0,    32'h0, 0, 32'h0, 0, 1, 1, 0, 0, 32'h0, 32'd0};
      tbl[10] = '{0, 0, 0, 1, 32'h0,  32'h1000, 32'h1, 0, 32'h0, 0, 1, 1, 0, 0, 32'h0, 32'd1};
      tbl[11] = '{0, 0, 0, 0, 32'h0,  32'h0,    32'h0, 0, 32'h0, 0, 0, 0, 1, 1, 32'h1, 32'd2};

      idle_inputs();
      rst_n = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      #1;
      chk("reset timeout", timeout, 0);
      chk("reset overflow", overflow, 0);
      chk("reset imem_we", imem_we, 0);

      // Load 3 words, hold 4 cycles, run, tohost write of 1.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         start = tbl[i].start; ld_valid = tbl[i].ld_valid; ld_last = tbl[i].ld_last;
         ld_data = tbl[i].ld_data; mon_write = tbl[i].mon_write;
         mon_addr = tbl[i].mon_addr; mon_data = tbl[i].mon_data;
         #1;
         chk($sformatf("row%0d imem_we", i), imem_we, tbl[i].we);
         if (tbl[i].we) begin
            chk($sformatf("row%0d imem_waddr", i), imem_waddr, tbl[i].waddr);
            chk($sformatf("row%0d imem_wdata", i), imem_wdata, tbl[i].ld_data);
         end
         chk($sformatf("row%0d ld_ready", i), ld_ready, tbl[i].ld_ready);
         chk($sformatf("row%0d core_rst_n", i), core_rst_n, tbl[i].crst);
         chk($sformatf("row%0d busy", i), busy, tbl[i].busy);
         chk($sformatf("row%0d done", i), done, tbl[i].done);
         chk($sformatf("row%0d pass", i), pass, tbl[i].pass);
         chk($sformatf("row%0d exit_code", i), exit_code, tbl[i].exit_code);
         chk($sformatf("row%0d cycle_count", i), cycle_count, tbl[i].cycle_count);
      end
      idle_inputs();

      // Failing exit code; a store to a neighbouring address is ignored.
      go_run(1);
      mon_write = 1; mon_addr = 32'h1004; mon_data = 32'h2A;
      @(negedge clk);
      mon_addr = 32'h1000;
      @(negedge clk);
      mon_write = 0;
      #1;
      chk("fail done", done, 1);
      chk("fail pass", pass, 0);
      chk("fail exit_code", exit_code, 32'h2A);
      chk("fail cycle_count", cycle_count, 2);
      chk("fail core_rst_n", core_rst_n, 0);

      // Timeout with no tohost store.
      go_run(2);
      repeat (49) @(negedge clk);
      #1;
      chk("pre-timeout done", done, 0);
      @(negedge clk);
      #1;
      chk("timeout done", done, 1);
      chk("timeout flag", timeout, 1);
      chk("timeout cycle_count", cycle_count, 50);
      chk("timeout exit_code", exit_code, 0);
      chk("timeout core_rst_n", core_rst_n, 0);

      // Tohost store in the timeout cycle wins.
      go_run(1);
      repeat (49) @(negedge clk);
      mon_write = 1; mon_addr = 32'h1000; mon_data = 32'h7;
      @(negedge clk);
      mon_write = 0;
      #1;
      chk("collide done", done, 1);
      chk("collide timeout", timeout, 0);
      chk("collide exit_code", exit_code, 7);
      chk("collide cycle_count", cycle_count, 50);

      // Overflow: 5 words without ld_last into a 4-word memory.
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      we_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         ld_valid = 1; ld_data = 32'h100 + i; ld_last = 0;
         #1;
         if (imem_we) begin
            chk($sformatf("ovf waddr%0d", i), imem_waddr, 32'(4 * i));
            we_cnt++;
         end
         chk($sformatf("ovf core_rst_n%0d", i), core_rst_n, 0);
         @(negedge clk);
      end
      ld_valid = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("ovf write count", we_cnt, 4);
      chk("ovf overflow", overflow, 1);
      chk("ovf done", done, 1);
      chk("ovf core_rst_n", core_rst_n, 0);

      // Abort during RUN.
      go_run(1);
      repeat (2) @(negedge clk);
      abort = 1;
      @(negedge clk);
      abort = 0;
      #1;
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort core_rst_n", core_rst_n, 0);
      chk("abort ld_ready", ld_ready, 0);

      // Asynchronous reset in the middle of LOAD.
      @(negedge clk); start = 1;
      @(negedge clk); start = 0; ld_valid = 1; ld_data = 32'h9;
      @(negedge clk); ld_valid = 0;
      #2;
      rst_n = 0;
      #1;
      chk("rst ld_ready", ld_ready, 0);
      chk("rst busy", busy, 0);
      chk("rst core_rst_n", core_rst_n, 0);
      chk("rst cycle_count", cycle_count, 0);
      chk("rst exit_code", exit_code, 0);
      @(negedge clk); rst_n = 1;

      // start and abort together: abort wins.
      @(negedge clk); start = 1; abort = 1;
      @(negedge clk); start = 0; abort = 0;
      #1;
      chk("start+abort busy", busy, 0);
      chk("start+abort ld_ready", ld_ready, 0);
      @(negedge clk);
      #1;
      chk("start+abort stays idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
